// File: rtl/updown_counter_prog.sv
// Programmable up/down counter: runtime limit, clamped step, load, wrap/saturate policy.
// Latency: one clk edge from inputs to q/ovf/udf; at_max/at_zero are combinational on q and lim.
// Backpressure: none; every enabled rising edge is accepted, en=0 holds the count.
module updown_counter_prog #(
  parameter int WIDTH  = 8,
  parameter int SWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_up,
  input  logic [SWIDTH-1:0] i_step,
  input  logic [WIDTH-1:0]  i_lim,
  input  logic              i_sat,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_ovf,
  output logic              o_udf,
  output logic              o_at_max,
  output logic              o_at_zero
);

  localparam int W1 = WIDTH + 1;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_udf;

  // All arithmetic is carried one bit wider than the count so sums never truncate.
  logic [W1-1:0]    w_q;
  logic [W1-1:0]    w_lim;
  logic [W1-1:0]    w_lim1;
  logic [W1-1:0]    w_step;
  logic [W1-1:0]    w_s;
  logic [W1-1:0]    w_sum;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_wrap;
  logic [WIDTH-1:0] w_up_plain;
  logic [WIDTH-1:0] w_dn_plain;
  logic             w_lim_zero;

  logic [WIDTH-1:0] w_nq;
  logic             w_novf;
  logic             w_nudf;

  assign w_q        = {1'b0, r_q};
  assign w_lim      = {1'b0, i_lim};
  assign w_lim1     = w_lim + W1'(1);
  assign w_step     = {{(W1-SWIDTH){1'b0}}, i_step};
  assign w_s        = (w_step < w_lim) ? w_step : w_lim;
  assign w_sum      = w_q + w_s;
  assign w_up_wrap  = WIDTH'(w_sum - w_lim1);
  assign w_dn_wrap  = WIDTH'(w_q + w_lim1 - w_s);
  assign w_up_plain = WIDTH'(w_sum);
  assign w_dn_plain = WIDTH'(w_q - w_s);
  assign w_lim_zero = (i_lim == '0);

  // Next count and event pulses: load beats enable beats hold.
  // With lim=0 the clamped step is 0, yet a non-zero step still counts as a
  // boundary crossing, so lim=0 is forced onto the overflow/underflow path.
  always_comb begin
    w_nq   = r_q;
    w_novf = 1'b0;
    w_nudf = 1'b0;
    if (i_load) begin
      w_nq = (i_load_val > i_lim) ? i_lim : i_load_val;
    end else if (i_en) begin
      if (r_q > i_lim) begin
        // Limit was lowered under the count: pull back into range.
        w_nq   = i_sat ? i_lim : '0;
        w_novf = 1'b1;
      end else if (i_step != '0) begin
        if (i_up) begin
          if ((w_sum > w_lim) || w_lim_zero) begin
            w_nq   = (i_sat || w_lim_zero) ? i_lim : w_up_wrap;
            w_novf = 1'b1;
          end else begin
            w_nq = w_up_plain;
          end
        end else begin
          if ((w_s > w_q) || w_lim_zero) begin
            w_nq   = (i_sat || w_lim_zero) ? '0 : w_dn_wrap;
            w_nudf = 1'b1;
          end else begin
            w_nq = w_dn_plain;
          end
        end
      end
    end
  end

  // Count and pulse registers, cleared asynchronously by active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_q   <= w_nq;
      r_ovf <= w_novf;
      r_udf <= w_nudf;
    end
  end

  assign o_q       = r_q;
  assign o_ovf     = r_ovf;
  assign o_udf     = r_udf;
  assign o_at_max  = (r_q == i_lim);
  assign o_at_zero = (r_q == '0);

endmodule

// File: tb/tb_updown_counter_prog.sv
// Bench for updown_counter_prog: directed boundary scenarios then random traffic.
// Reference is an integer model of the counting rules, updated at each rising edge.
// Outputs are sampled 1ns after the rising edge; inputs change only at that point.
module tb_updown_counter_prog;

  localparam int WIDTH  = 4;
  localparam int SWIDTH = 4;

  logic              clk;
  logic              rst;
  logic              i_en;
  logic              i_up;
  logic [SWIDTH-1:0] i_step;
  logic [WIDTH-1:0]  i_lim;
  logic              i_sat;
  logic              i_load;
  logic [WIDTH-1:0]  i_load_val;
  logic [WIDTH-1:0]  o_q;
  logic              o_ovf;
  logic              o_udf;
  logic              o_at_max;
  logic              o_at_zero;

  int n_checks;
  int n_errors;

  // Reference state
  int m_q;
  bit m_ovf;
  bit m_udf;

  updown_counter_prog #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_up       (i_up),
    .i_step     (i_step),
    .i_lim      (i_lim),
    .i_sat      (i_sat),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_q        (o_q),
    .o_ovf      (o_ovf),
    .o_udf      (o_udf),
    .o_at_max   (o_at_max),
    .o_at_zero  (o_at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Counting rules in plain integer arithmetic.
  task automatic model_edge();
    int l, st, s, t;
    l     = int'(i_lim);
    st    = int'(i_step);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (i_load) begin
      m_q = (int'(i_load_val) > l) ? l : int'(i_load_val);
    end else if (i_en) begin
      if (m_q > l) begin
        m_q   = i_sat ? l : 0;
        m_ovf = 1'b1;
      end else if (st != 0) begin
        s = (st < l) ? st : l;
        if (i_up) begin
          t = m_q + s;
          if (t > l || l == 0) begin
            m_q   = i_sat ? l : (t % (l + 1));
            m_ovf = 1'b1;
          end else begin
            m_q = t;
          end
        end else begin
          t = m_q - s;
          if (t < 0 || l == 0) begin
            m_q   = i_sat ? 0 : ((t + l + 1) % (l + 1));
            m_udf = 1'b1;
          end else begin
            m_q = t;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},       int'(o_q),       m_q);
    chk({tag, ".ovf"},     int'(o_ovf),     int'(m_ovf));
    chk({tag, ".udf"},     int'(o_udf),     int'(m_udf));
    chk({tag, ".at_max"},  int'(o_at_max),  int'(m_q == int'(i_lim)));
    chk({tag, ".at_zero"}, int'(o_at_zero), int'(m_q == 0));
  endtask

  // One rising edge: update the model from the sampled inputs, then compare.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit en, input bit up, input int step, input int lim,
                        input bit sat, input bit load, input int lval);
    i_en       = en;
    i_up       = up;
    i_step     = SWIDTH'(step);
    i_lim      = WIDTH'(lim);
    i_sat      = sat;
    i_load     = load;
    i_load_val = WIDTH'(lval);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_q = 0; m_ovf = 0; m_udf = 0;
    rst = 1'b0;
    set_in(0, 0, 0, 15, 0, 0, 0);
    #12;
    chk("reset.q",   int'(o_q),   0);
    chk("reset.ovf", int'(o_ovf), 0);
    chk("reset.udf", int'(o_udf), 0);
    chk("reset.at_zero", int'(o_at_zero), 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset mid-count: count to 5, drop reset between edges.
    set_in(1, 1, 1, 15, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("cnt");
    chk("midcnt.q5", int'(o_q), 5);
    #2 rst = 1'b0;
    #1;
    m_q = 0; m_ovf = 0; m_udf = 0;
    chk("arst.q",   int'(o_q),   0);
    chk("arst.ovf", int'(o_ovf), 0);
    chk("arst.udf", int'(o_udf), 0);
    rst = 1'b1;
    cyc("post_rst");
    chk("post_rst.q1", int'(o_q), 1);

    // Wrap up: lim=9, q=8, step=3 -> 1 with ovf, then 4.
    set_in(0, 1, 3, 9, 0, 1, 8);
    cyc("ld8");
    set_in(1, 1, 3, 9, 0, 0, 0);
    cyc("wrap1");
    chk("wrap.q1", int'(o_q), 1);
    chk("wrap.ovf1", int'(o_ovf), 1);
    cyc("wrap2");
    chk("wrap.q4", int'(o_q), 4);
    chk("wrap.ovf0", int'(o_ovf), 0);

    // Saturate down: lim=9, q=2, step=4 -> 0 with udf on every edge.
    set_in(0, 0, 4, 9, 1, 1, 2);
    cyc("ld2");
    set_in(1, 0, 4, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("satdn");
      chk("satdn.udf", int'(o_udf), 1);
    end

    // Load clamp beats enable, then wrap from lim.
    set_in(1, 1, 1, 6, 0, 1, 12);
    cyc("ldclamp");
    chk("ldclamp.q6", int'(o_q), 6);
    set_in(1, 1, 1, 6, 0, 0, 0);
    cyc("ldwrap");
    chk("ldwrap.q0", int'(o_q), 0);
    chk("ldwrap.ovf", int'(o_ovf), 1);

    // Runtime limit drop below the count.
    set_in(0, 1, 1, 15, 1, 1, 9);
    cyc("ld9");
    set_in(1, 1, 1, 5, 1, 0, 0);
    #1;
    chk("limdrop.at_max_pre", int'(o_at_max), 0);
    cyc("limdrop");
    chk("limdrop.q5", int'(o_q), 5);
    chk("limdrop.at_max", int'(o_at_max), 1);

    // Step clamp, then lim=0.
    set_in(0, 1, 15, 3, 0, 1, 0);
    cyc("ld0");
    set_in(1, 1, 15, 3, 0, 0, 0);
    cyc("stepclamp");
    chk("stepclamp.q3", int'(o_q), 3);
    set_in(1, 1, 15, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("lim0");
      chk("lim0.ovf", int'(o_ovf), 1);
      chk("lim0.both", int'(o_at_max & o_at_zero), 1);
    end

    // Natural binary wrap at full-range limit.
    set_in(0, 1, 1, 15, 0, 1, 15);
    cyc("ld15");
    set_in(1, 1, 1, 15, 0, 0, 0);
    cyc("natwrap");
    chk("natwrap.q0", int'(o_q), 0);

    // Random traffic with an occasionally moving limit.
    for (int i = 0; i < 600; i++) begin
      i_en       = ($urandom_range(0, 9) != 0);
      i_up       = $urandom_range(0, 1) == 1;
      i_step     = SWIDTH'($urandom_range(0, 15));
      i_sat      = $urandom_range(0, 1) == 1;
      i_load     = ($urandom_range(0, 11) == 0);
      i_load_val = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) i_lim = WIDTH'($urandom_range(0, 15));
      cyc("rnd");
      chk("rnd.excl", int'(o_ovf & o_udf), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
